// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - time-multiplexed multi-channel FIR with loadable coefficients
//
// One sample is accepted at a time and written into its channel's circular
// delay line. TAPS multiply-accumulates then run, one per clock, against the
// shared coefficient set. The sum is shifted, saturated and held on the output
// until it is taken.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_chan       signed input sample and its channel
//   in_valid/in_ready     input handshake (ready only in IDLE)
//   out_data/out_chan     saturated filter result and its channel
//   out_valid/out_ready   output handshake (valid only in OUT)
//   coef_we/addr/data     coefficient write port, honoured only in IDLE
//   busy                  high in every state except IDLE
module fir_filter_mc #(
  parameter int DATA_W   = 24,
  parameter int COEF_W   = 24,
  parameter int TAPS     = 128,
  parameter int CHANNELS = 2,
  parameter int SHIFT    = 18,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CH_W-1:0]          in_chan,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     busy
);

  localparam int KW     = $clog2(TAPS);
  localparam int DA_W   = CH_W + KW;
  localparam int INIT_N = TAPS * CHANNELS;
  localparam int IW     = $clog2(INIT_N);
  localparam int PW     = DATA_W + COEF_W;
  // MAC counter runs 0..TAPS+2: TAPS issue cycles plus three drain cycles.
  localparam int CW     = KW + 2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_MAC, S_OUT} state_t;
  state_t state, state_nx;

  // Delay lines are addressed as {channel, tap}.
  logic [DATA_W-1:0] delay_mem [2**DA_W];
  logic [COEF_W-1:0] coef_mem  [TAPS];
  logic [KW-1:0]     wr_ptr    [2**CH_W];

  logic [IW-1:0]            init_cnt;
  logic [CW-1:0]            mac_cnt;
  logic [CH_W-1:0]          ch;
  logic                     rd_vld;
  logic                     mul_vld;
  logic [DATA_W-1:0]        rd_data;
  logic [COEF_W-1:0]        rd_coef;
  logic [PW-1:0]            prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [DATA_W-1:0]        sat;
  logic [KW-1:0]            rd_tap;
  logic                     init_last;
  logic                     mac_issue;
  logic                     mac_last;
  logic                     in_xfer;
  logic                     out_xfer;

  assign init_last = (init_cnt == IW'(INIT_N - 1));
  assign mac_issue = (state == S_MAC) && (mac_cnt < CW'(TAPS));
  assign mac_last  = (state == S_MAC) && (mac_cnt == CW'(TAPS + 2));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // Tap k reads the sample written k acceptances ago; k=0 is the newest.
  assign rd_tap    = wr_ptr[ch] - mac_cnt[KW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (init_last) state_nx = S_IDLE;
      S_IDLE:  if (in_xfer)   state_nx = S_MAC;
      S_MAC:   if (mac_last)  state_nx = S_OUT;
      S_OUT:   if (out_xfer)  state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Storage and datapath pipeline (address -> read -> multiply). The coefficient
  // write is ordered before the first read, so a write coincident with an input
  // transfer applies to that sample.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      delay_mem[DA_W'(init_cnt)]  <= '0;
      coef_mem[init_cnt[KW-1:0]]  <= '0;
    end else if (state == S_IDLE) begin
      if (coef_we)  coef_mem[coef_addr] <= coef_data;
      if (in_valid) delay_mem[{in_chan, wr_ptr[in_chan]}] <= in_data;
    end
    rd_coef <= coef_mem[mac_cnt[KW-1:0]];
    rd_data <= delay_mem[{ch, rd_tap}];
    prod    <= $signed({{COEF_W{rd_data[DATA_W-1]}}, rd_data}) *
               $signed({{DATA_W{rd_coef[COEF_W-1]}}, rd_coef});
  end

  // Shift then saturate: in range only if all bits above the result sign agree.
  always_comb begin
    acc_sh = acc >>> SHIFT;
    sat    = acc_sh[DATA_W-1:0];
    if (!((&acc_sh[ACC_W-1:DATA_W-1]) || !(|acc_sh[ACC_W-1:DATA_W-1]))) begin
      sat = acc_sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Control counters, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
      mac_cnt  <= '0;
      ch       <= '0;
      rd_vld   <= 1'b0;
      mul_vld  <= 1'b0;
      acc      <= '0;
      out_data <= '0;
      out_chan <= '0;
      for (int i = 0; i < 2**CH_W; i++) wr_ptr[i] <= '0;
    end else begin
      rd_vld  <= mac_issue;
      mul_vld <= rd_vld;
      if (state == S_INIT) init_cnt <= init_cnt + IW'(1);
      if (in_xfer) begin
        ch      <= in_chan;
        mac_cnt <= '0;
        acc     <= '0;
      end else if (state == S_MAC) begin
        mac_cnt <= mac_cnt + CW'(1);
        if (mul_vld) acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
      end
      if (mac_last) begin
        out_data <= sat;
        out_chan <= ch;
      end
      if (out_xfer) wr_ptr[ch] <= wr_ptr[ch] + KW'(1);
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb/tb_fir_filter_mc.sv - directed self-checking bench for fir_filter_mc
module tb_fir_filter_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_chan;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_filter_mc #(
    .DATA_W(16), .COEF_W(16), .TAPS(8), .CHANNELS(2), .SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_chan(in_chan), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic load_coef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = 3'(k);
    coef_data = 16'(v);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic init_sweep(input string tag);
    int n;
    logic ov;
    n  = 0;
    ov = 1'b0;
    while (!in_ready && n < 100) begin
      if (out_valid) ov = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, 32'(n), 16);
    chk({tag, "_out_valid_low"}, 32'(ov), 0);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
  endtask

  task automatic put_in(input logic c, input int d, input logic cwe, input int ca, input int cd);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_chan   = c;
    in_data   = 16'(d);
    coef_we   = cwe;
    coef_addr = 3'(ca);
    coef_data = 16'(cd);
    @(negedge clk);
    in_valid  = 1'b0;
    coef_we   = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_wait", 32'(out_valid), 1);
    lat = n;
  endtask

  task automatic take_out(output logic signed [15:0] r, output logic rc);
    r  = out_data;
    rc = out_chan;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic xfer(input logic c, input int d, output logic signed [15:0] r,
                      output logic rc, output int lat);
    put_in(c, d, 1'b0, 0, 0);
    wait_out(lat);
    take_out(r, rc);
  endtask

  initial begin
    logic signed [15:0] r;
    logic signed [15:0] d0;
    logic               rc;
    logic               stable;
    int                 lat;

    rst_n = 1'b0; in_valid = 1'b0; in_chan = 1'b0; in_data = '0;
    out_ready = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_chan", 32'(out_chan), 0);
    rst_n = 1'b1;
    init_sweep("init1");

    // Impulse 100 through coefficients 1..8
    for (int k = 0; k < 8; k++) load_coef(k, k + 1);
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, (i == 0) ? 100 : 0, r, rc, lat);
      chk("impulse_out", 32'(r), 100 * (i + 1));
      chk("impulse_chan", 32'(rc), 0);
      if (i == 0) chk("impulse_latency", 32'(lat), 11);
    end

    // Interleaved channels, unit coefficients
    for (int k = 0; k < 8; k++) load_coef(k, 1);
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, (i == 0) ? 1 : 0, r, rc, lat);
      chk("ch0_out", 32'(r), (i < 8) ? 1 : 0);
      chk("ch0_chan", 32'(rc), 0);
      xfer(1'b1, 5, r, rc, lat);
      chk("ch1_out", 32'(r), 5 * ((i < 8) ? i + 1 : 8));
      chk("ch1_chan", 32'(rc), 1);
    end

    // Output back-pressure with a pending input
    put_in(1'b1, 5, 1'b0, 0, 0);
    wait_out(lat);
    d0     = out_data;
    stable = 1'b1;
    in_valid = 1'b1; in_chan = 1'b1; in_data = 16'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data !== d0 || !out_valid || in_ready) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 1);
    chk("hold_value", 32'(d0), 40);
    take_out(r, rc);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("pending_latency", 32'(lat), 11);
    take_out(r, rc);
    chk("pending_out", 32'(r), 42);
    chk("pending_chan", 32'(rc), 1);

    // Saturation both ways
    for (int k = 0; k < 8; k++) load_coef(k, 32767);
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 32767, r, rc, lat);
      chk("sat_pos", 32'(r), 32767);
    end
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, -32768, r, rc, lat);
      if (i == 0) chk("sat_mixed", 32'(r), 32767);
      if (i == 7) chk("sat_neg", 32'(r), -32768);
    end

    // Coefficient write during MAC is ignored; coincident IDLE write applies
    load_coef(0, 1);
    for (int k = 1; k < 8; k++) load_coef(k, 0);
    put_in(1'b0, 3, 1'b0, 0, 0);
    @(negedge clk);
    load_coef(7, 1);
    chk("mac_busy", 32'(busy), 1);
    wait_out(lat);
    take_out(r, rc);
    chk("coef_we_in_mac", 32'(r), 3);
    put_in(1'b0, 4, 1'b1, 0, 2);
    wait_out(lat);
    take_out(r, rc);
    chk("coef_we_coincident", 32'(r), 8);

    // Reset mid-MAC
    put_in(1'b0, 9, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mac_out_valid", 32'(out_valid), 0);
    chk("rst_mac_in_ready", 32'(in_ready), 0);
    chk("rst_mac_busy", 32'(busy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    init_sweep("init2");
    xfer(1'b0, 9, r, rc, lat);
    chk("coef_cleared", 32'(r), 0);
    for (int k = 0; k < 8; k++) load_coef(k, 1);
    xfer(1'b0, 2, r, rc, lat);
    chk("delay_cleared", 32'(r), 11);

    // Reset while the result is presented
    put_in(1'b1, 6, 1'b0, 0, 0);
    wait_out(lat);
    chk("pre_rst_out", 32'($signed(out_data)), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    init_sweep("init3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
